// File: rtl/vector_reduce_pkg.sv
// Shared definitions for the vector reduction unit: the op encodings, the
// FSM state codes and the per-op accumulator identity values.
package vector_reduce_pkg;

  typedef logic [2:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_ADD  = 3'd0;
  localparam op_t OP_AND  = 3'd1;
  localparam op_t OP_OR   = 3'd2;
  localparam op_t OP_XOR  = 3'd3;
  localparam op_t OP_SMIN = 3'd4;
  localparam op_t OP_SMAX = 3'd5;
  localparam op_t OP_UMIN = 3'd6;
  localparam op_t OP_UMAX = 3'd7;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [31:0] ID_ZERO = 32'h0000_0000;
  localparam logic [31:0] ID_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] ID_SMAX = 32'h8000_0000;
  localparam logic [31:0] ID_SMIN = 32'h7FFF_FFFF;

  // Unknown encodings behave as OR, whose identity is zero.
  function automatic logic [31:0] identity_f(input op_t op);
    logic [31:0] id;
    case (op)
      OP_AND, OP_UMIN: id = ID_ONES;
      OP_SMAX:         id = ID_SMAX;
      OP_SMIN:         id = ID_SMIN;
      default:         id = ID_ZERO;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/vector_reduce_combine.sv
// Combinational two-operand combine step shared by all reduction ops.
module vector_reduce_combine
  import vector_reduce_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result
);

  // Select the combine function for the requested op.
  always_comb begin
    result = a | b;
    case (op)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SMIN: result = ($signed(a) < $signed(b)) ? a : b;
      OP_SMAX: result = ($signed(a) > $signed(b)) ? a : b;
      OP_UMIN: result = (a < b) ? a : b;
      OP_UMAX: result = (a > b) ? a : b;
      default: result = a | b;
    endcase
  end

endmodule

// File: rtl/vector_reduce_unit.sv
// Sequential lane-by-lane masked reduction of a vector operand to one scalar,
// with a valid/ready request side and a valid/ready result side.
module vector_reduce_unit
  import vector_reduce_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int LANE_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [2:0]                  op_i,
  input  logic [LANES*LANE_WIDTH-1:0] vector_i,
  input  logic [LANES-1:0]            mask_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [LANE_WIDTH-1:0]       result_o
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  op_t                   op_q, op_d;
  logic [LANE_WIDTH-1:0] vec_q [LANES];
  logic [LANE_WIDTH-1:0] vec_d [LANES];
  logic [LANES-1:0]      mask_q, mask_d;
  logic [LANE_WIDTH-1:0] acc_q, acc_d;
  logic [LANE_WIDTH-1:0] lane_q, lane_d;
  logic                  lane_en_q, lane_en_d;
  logic                  pend_q, pend_d;
  logic                  last_q, last_d;
  logic [LANE_WIDTH-1:0] comb_res_s;

  vector_reduce_combine #(.W(LANE_WIDTH)) u_combine (
    .op     (op_q),
    .a      (acc_q),
    .b      (lane_q),
    .result (comb_res_s)
  );

  // Next-state logic. Lane operands are fetched into lane_q one cycle ahead of
  // being combined, keeping the lane select mux out of the combine path; that
  // stage is what makes the result appear LANES+1 cycles after acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    vec_d     = vec_q;
    mask_d    = mask_q;
    acc_d     = acc_q;
    lane_d    = lane_q;
    lane_en_d = lane_en_q;
    pend_d    = pend_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          op_d    = op_i;
          mask_d  = mask_i;
          for (int i = 0; i < LANES; i++) begin
            vec_d[i] = vector_i[i*LANE_WIDTH +: LANE_WIDTH];
          end
          acc_d     = LANE_WIDTH'(identity_f(op_i));
          lane_en_d = 1'b0;
          pend_d    = 1'b0;
          last_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pend_q && lane_en_q) begin
          acc_d = comb_res_s;
        end else begin
          acc_d = acc_q;
        end
        if (last_q) begin
          state_d = ST_DONE;
          pend_d  = 1'b0;
          last_d  = 1'b0;
        end else begin
          lane_d    = vec_q[cnt_q];
          lane_en_d = mask_q[cnt_q];
          pend_d    = 1'b1;
          last_d    = (cnt_q == LAST_LANE);
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight reduction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      mask_q    <= '0;
      acc_q     <= '0;
      lane_q    <= '0;
      lane_en_q <= 1'b0;
      pend_q    <= 1'b0;
      last_q    <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      acc_q     <= acc_d;
      lane_q    <= lane_d;
      lane_en_q <= lane_en_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
      vec_q     <= vec_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign result_o    = acc_q;

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Directed self-checking bench for vector_reduce_unit (16 lanes x 32 bits).
module tb_vector_reduce_unit;

  localparam int LANES = 16;
  localparam int LW    = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       op_i;
  logic [LANES*LW-1:0] vector_i;
  logic [LANES-1:0] mask_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [LW-1:0]    result_o;

  int tests_run;
  int tests_failed;

  vector_reduce_unit #(.LANES(LANES), .LANE_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .vector_i    (vector_i),
    .mask_i      (mask_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LANES*LW-1:0] ramp_vec();
    logic [LANES*LW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LW +: LW] = 32'(i + 1);
    return v;
  endfunction

  function automatic logic [LANES*LW-1:0] fill_vec(input logic [LW-1:0] val);
    logic [LANES*LW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LW +: LW] = val;
    return v;
  endfunction

  // Issue one request, scramble the inputs after acceptance, and wait for
  // out_valid_o. lat = edges from accept to valid, -1 on timeout.
  task automatic do_req(input logic [2:0] op, input logic [LANES*LW-1:0] vec,
                        input logic [LANES-1:0] mask,
                        output logic [LW-1:0] res, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    op_i = op; vector_i = vec; mask_i = mask; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0; op_i = op ^ 3'd1; vector_i = ~vec; mask_i = ~mask;
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid_o) lat = -1;
    res = result_o;
  endtask

  task automatic finish_hs();
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = 3'd0; vector_i = '0; mask_i = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got %0b want 0", out_valid_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready got %0b want 1", in_ready_o);
    end
    tests_run++;
    if (result_o !== 32'h0) begin
      tests_failed++; $display("FAIL reset_result got %h want 00000000", result_o);
    end
  endtask

  task automatic test_add();
    logic [LW-1:0] r; int lat;
    do_req(3'd0, ramp_vec(), 16'hFFFF, r, lat);
    tests_run++;
    if (r !== 32'h0000_0088) begin
      tests_failed++; $display("FAIL add_result got %h want 00000088", r);
    end
    tests_run++;
    if (lat !== 17) begin
      tests_failed++; $display("FAIL add_latency got %0d want 17", lat);
    end
    finish_hs();
  endtask

  task automatic test_minmax();
    logic [LANES*LW-1:0] v; logic [LW-1:0] r; int lat;
    logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd7, 3'd5};
    logic [31:0] exps [4] = '{32'hFFFF_FFF0, 32'h0000_0003, 32'hFFFF_FFF0, 32'h0000_0003};
    v = fill_vec(32'h3);
    v[5*LW +: LW] = 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) begin
      do_req(ops[k], v, 16'hFFFF, r, lat);
      tests_run++;
      if (r !== exps[k]) begin
        tests_failed++; $display("FAIL minmax_op%0d got %h want %h", ops[k], r, exps[k]);
      end
      finish_hs();
    end
  endtask

  task automatic test_empty_mask();
    logic [LW-1:0] r; int lat;
    do_req(3'd1, ramp_vec(), 16'h0000, r, lat);
    tests_run++;
    if (r !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL and_empty got %h want ffffffff", r);
    end
    tests_run++;
    if (lat !== 17) begin
      tests_failed++; $display("FAIL and_empty_latency got %0d want 17", lat);
    end
    finish_hs();
    do_req(3'd5, ramp_vec(), 16'h0000, r, lat);
    tests_run++;
    if (r !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL smax_empty got %h want 80000000", r);
    end
    tests_run++;
    if (lat !== 17) begin
      tests_failed++; $display("FAIL smax_empty_latency got %0d want 17", lat);
    end
    finish_hs();
  endtask

  task automatic test_xor();
    logic [LW-1:0] r; int lat;
    do_req(3'd3, fill_vec(32'hA5A5_A5A5), 16'h00FF, r, lat);
    tests_run++;
    if (r !== 32'h0000_0000) begin
      tests_failed++; $display("FAIL xor_even got %h want 00000000", r);
    end
    finish_hs();
    do_req(3'd3, fill_vec(32'hA5A5_A5A5), 16'h0001, r, lat);
    tests_run++;
    if (r !== 32'hA5A5_A5A5) begin
      tests_failed++; $display("FAIL xor_single got %h want a5a5a5a5", r);
    end
    finish_hs();
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] held; int cyc; int bad;
    @(negedge clk);
    op_i = 3'd2; vector_i = ramp_vec(); mask_i = 16'hFFFF; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    bad = 0;
    // Pulse foreign requests throughout RUN; none may be taken.
    cyc = 0;
    while (!out_valid_o && cyc < 40) begin
      @(negedge clk);
      in_valid_i = cyc[0]; op_i = 3'd1; vector_i = fill_vec(32'hFFFF_FFFF);
      if (in_ready_o !== 1'b0) bad++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_i = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL run_ready_high got %0d cycles want 0", bad);
    end
    tests_run++;
    if (result_o !== 32'h0000_001F || out_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL or_result got %h/%0b want 0000001f/1", result_o, out_valid_o);
    end
    held = result_o;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_o !== 1'b1 || result_o !== held || in_ready_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    // Present the next request in the handshake cycle itself.
    op_i = 3'd0; vector_i = ramp_vec(); mask_i = 16'hFFFF;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    tests_run++;
    if (in_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL hs_ready got %0b want 0", in_ready_o);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    tests_run++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL idle_gap got valid %0b ready %0b want 0/1", out_valid_o, in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    cyc = 0;
    while (!out_valid_o && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (cyc !== 17 || result_o !== 32'h0000_0088) begin
      tests_failed++; $display("FAIL b2b_add got lat %0d res %h want 17/00000088", cyc, result_o);
    end
    finish_hs();
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] r; int lat; int bad;
    @(negedge clk);
    op_i = 3'd0; vector_i = ramp_vec(); mask_i = 16'hFFFF; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 32'h0) begin
      tests_failed++; $display("FAIL mid_reset got v%0b r%0b res %h want 0/1/00000000", out_valid_o, in_ready_o, result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid_o !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL abandoned_valid got %0d cycles want 0", bad);
    end
    do_req(3'd0, fill_vec(32'hFFFF_FFFF), 16'h0003, r, lat);
    tests_run++;
    if (r !== 32'hFFFF_FFFE || lat !== 17) begin
      tests_failed++; $display("FAIL post_reset_add got %h lat %0d want fffffffe/17", r, lat);
    end
    finish_hs();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_add();
    test_minmax();
    test_empty_mask();
    test_xor();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vector_reduce_unit.md
VECTOR_REDUCE_UNIT -- requirements
Module: vector_reduce_unit

Interface
REQ-001 SHALL have parameter LANES, default 16, number of 32-bit lanes in the vector operand.
REQ-002 SHALL have parameter LANE_WIDTH, default 32, bits per lane.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid_i  input  1  request valid.
REQ-006 SHALL have port in_ready_o  output  1  unit can accept a request.
REQ-007 SHALL have port op_i  input  3  reduction operation, encoding from the shared package.
REQ-008 SHALL have port vector_i  input  LANES*LANE_WIDTH  operand; lane n occupies bits [n*32+31:n*32].
REQ-009 SHALL have port mask_i  input  LANES  bit n enables lane n.
REQ-010 SHALL have port out_valid_o  output  1  result valid.
REQ-011 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-012 SHALL have port result_o  output  LANE_WIDTH  reduced scalar.

Function
REQ-013 SHALL support ops ADD (wrap mod 2^32), AND, OR, XOR, SMIN, SMAX, UMIN, UMAX.
REQ-014 SHALL accept a request only in IDLE, when in_valid_i and in_ready_o are both high; in_ready_o = (state == IDLE).
REQ-015 SHALL capture op_i, vector_i and mask_i into internal registers on acceptance; later input changes have no effect.
REQ-016 SHALL initialise the accumulator on acceptance to the op identity: ADD/OR/XOR/UMAX 0x00000000, AND/UMIN 0xFFFFFFFF, SMAX 0x80000000, SMIN 0x7FFFFFFF.
REQ-017 SHALL use states IDLE, RUN and DONE: IDLE->RUN on accept; RUN->DONE after lane LANES-1; DONE->IDLE when out_ready_i is high.
REQ-018 SHALL process exactly one lane per RUN cycle in order lane 0 to lane LANES-1, tracked by a lane counter of clog2(LANES) bits cleared on accept.
REQ-019 SHALL replace the accumulator with combine(acc, lane) for a lane whose mask bit is 1 and leave it unchanged for a lane whose mask bit is 0.
REQ-020 SHALL have fixed latency: out_valid_o rises LANES+1 cycles after the accept edge, independent of mask contents, with no early termination.
REQ-021 SHALL hold out_valid_o = (state == DONE) and keep result_o stable until the handshake completes.
REQ-022 SHALL return the identity value of REQ-016 when mask_i is all zeros.
REQ-023 SHALL keep in_ready_o low in the cycle of the DONE->IDLE handshake, so back-to-back requests incur one idle cycle.
REQ-024 SHALL treat an op_i encoding outside REQ-013 as OR.

Reset
REQ-025 SHALL, while rst_n is low, force state IDLE, lane counter 0, accumulator 0, in_ready_o 1 after reset completes, out_valid_o 0 and result_o 0.
REQ-026 SHALL, when reset asserts in RUN or DONE, abandon the operation with no result output; the first accept after rst_n deasserts starts a fresh reduction.

Structure
REQ-027 SHALL take the op encodings, identity constants and state enumeration from shared package vector_reduce_pkg.
REQ-028 SHALL implement the combinational two-operand combine in sub-module vector_reduce_combine (inputs op, a, b; output 32-bit result), instantiated once.
REQ-029 SHALL contain no multiplier and no more than one combine instance.

Verification
REQ-030 Scenario: ADD, lanes n = n+1, mask 0xFFFF -> result 136 (0x88), out_valid_o 17 cycles after accept.
REQ-031 Scenario: SMIN, lane 5 = 0xFFFFFFF0, others 3, mask 0xFFFF -> 0xFFFFFFF0; same data with UMIN -> 0x00000003.
REQ-032 Scenario: AND, mask 0x0000 -> 0xFFFFFFFF; SMAX, mask 0x0000 -> 0x80000000; both with the same 17-cycle latency.
REQ-033 Scenario: XOR, all lanes 0xA5A5A5A5, mask 0x00FF -> 0x00000000; mask 0x0001 -> 0xA5A5A5A5.
REQ-034 Scenario: out_ready_i held low for 10 cycles in DONE -> result_o and out_valid_o stable, in_ready_o low; in_valid_i pulses during RUN are ignored.
REQ-035 Scenario: rst_n pulsed low at lane 7 of an ADD -> no out_valid_o; a new ADD of all-ones lanes, mask 0x0003, then returns 0xFFFFFFFE.
